// File: rtl/game_board_if.sv
// Handshake and board bus between the game controller and its environment.
// Clock and reset stay as plain ports on the modules that use this bundle.
interface game_board_if;
  logic       Start;
  logic       Ack;
  logic       bottom_flag;
  logic       top_flag;
  logic [3:0] x1, y1, x2, y2, x3, y3, x4, y4;

  logic       gen_flag;
  logic [9:0] arr0, arr1, arr2, arr3, arr4, arr5;
  logic [9:0] arr6, arr7, arr8, arr9, arr10, arr11;
  logic [7:0] lines_cleared;
  logic       game_over;
  logic [2:0] state;

  modport master (
    output Start, Ack, bottom_flag, top_flag,
    output x1, y1, x2, y2, x3, y3, x4, y4,
    input  gen_flag, lines_cleared, game_over, state,
    input  arr0, arr1, arr2, arr3, arr4, arr5,
    input  arr6, arr7, arr8, arr9, arr10, arr11
  );

  modport slave (
    input  Start, Ack, bottom_flag, top_flag,
    input  x1, y1, x2, y2, x3, y3, x4, y4,
    output gen_flag, lines_cleared, game_over, state,
    output arr0, arr1, arr2, arr3, arr4, arr5,
    output arr6, arr7, arr8, arr9, arr10, arr11
  );
endinterface

// File: rtl/game_board.sv
// Falling-block board controller: locks landed pieces into a 10x12 grid and clears full rows.
// Optional macro LINES_CLEARED_EN implements the saturating cleared-row counter.
module game_board (
  input  logic  Clk,
  input  logic  Reset_n,
  game_board_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    PLAY  = 3'd2,
    LOCK  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] board_q [12];
  logic [9:0] board_d [12];
  logic [3:0] cx_q [4];
  logic [3:0] cy_q [4];
  logic [3:0] r_q, r_d;
  logic       row_full;

  // r never exceeds 11 because CLEAR leaves for GEN after examining row 11.
  assign row_full = (board_q[r_q] == 10'h3FF);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      IDLE:  if (bus.Start) state_d = GEN;
      GEN:   state_d = PLAY;
      PLAY:  if (bus.bottom_flag) state_d = LOCK;
      LOCK: begin
        if (bus.top_flag) begin
          state_d = OVER;
        end else begin
          state_d = CLEAR;
          r_d     = '0;
        end
      end
      CLEAR: begin
        // A full row is re-examined after the shift, so r only advances on a non-full row.
        if (!row_full) begin
          if (r_q == 4'd11) state_d = GEN;
          else              r_d = r_q + 4'd1;
        end
      end
      OVER:  if (bus.Ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 12; i++) board_d[i] = board_q[i];
    case (state_q)
      LOCK: begin
        for (int k = 0; k < 4; k++) begin
          if (cx_q[k] <= 4'd9 && cy_q[k] <= 4'd11)
            board_d[cy_q[k]][cx_q[k]] = 1'b1;
        end
      end
      CLEAR: begin
        if (row_full) begin
          for (int i = 0; i < 11; i++) begin
            if (4'(i) >= r_q) board_d[i] = board_q[i+1];
          end
          board_d[11] = '0;
        end
      end
      OVER: begin
        if (bus.Ack) begin
          for (int i = 0; i < 12; i++) board_d[i] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 12; i++) board_q[i] <= '0;
    end else begin
      for (int i = 0; i < 12; i++) board_q[i] <= board_d[i];
    end
  end

  // Cells are captured on the landing edge; LOCK uses only these copies.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < 4; k++) begin
        cx_q[k] <= '0;
        cy_q[k] <= '0;
      end
    end else if (state_q == PLAY && bus.bottom_flag) begin
      cx_q[0] <= bus.x1;
      cy_q[0] <= bus.y1;
      cx_q[1] <= bus.x2;
      cy_q[1] <= bus.y2;
      cx_q[2] <= bus.x3;
      cy_q[2] <= bus.y3;
      cx_q[3] <= bus.x4;
      cy_q[3] <= bus.y4;
    end
  end

`ifdef LINES_CLEARED_EN
  logic [7:0] lines_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lines_q <= '0;
    end else if (state_q == IDLE && bus.Start) begin
      lines_q <= '0;
    end else if (state_q == CLEAR && row_full && lines_q != 8'hFF) begin
      lines_q <= lines_q + 8'd1;
    end
  end

  assign bus.lines_cleared = lines_q;
`else
  assign bus.lines_cleared = 8'd0;
`endif

  assign bus.gen_flag  = (state_q == GEN);
  assign bus.game_over = (state_q == OVER);
  assign bus.state     = state_q;

  assign bus.arr0  = board_q[0];
  assign bus.arr1  = board_q[1];
  assign bus.arr2  = board_q[2];
  assign bus.arr3  = board_q[3];
  assign bus.arr4  = board_q[4];
  assign bus.arr5  = board_q[5];
  assign bus.arr6  = board_q[6];
  assign bus.arr7  = board_q[7];
  assign bus.arr8  = board_q[8];
  assign bus.arr9  = board_q[9];
  assign bus.arr10 = board_q[10];
  assign bus.arr11 = board_q[11];

endmodule

// File: tb/tb_game_board.sv
// Directed bench for game_board: reset, piece locking, row clearing, game over and async reset.
module tb_game_board;

`ifdef LINES_CLEARED_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic Clk;
  logic Reset_n;
  int   n_checks;
  int   n_errors;
  int   n_cyc;

  game_board_if bus ();

  game_board dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] exp_lines(input int n);
    return LC_EN ? 8'(n) : 8'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents a landed piece in PLAY, then scrambles the coordinate inputs during LOCK.
  task automatic lock_piece(input int ax, input int ay, input int bx, input int by,
                            input int cx, input int cy, input int dx, input int dy,
                            input logic top);
    bus.x1 = 4'(ax); bus.y1 = 4'(ay);
    bus.x2 = 4'(bx); bus.y2 = 4'(by);
    bus.x3 = 4'(cx); bus.y3 = 4'(cy);
    bus.x4 = 4'(dx); bus.y4 = 4'(dy);
    bus.bottom_flag = 1'b1;
    bus.top_flag    = top;
    step();
    check("lock_state", 32'(bus.state), 32'd3);
    bus.bottom_flag = 1'b0;
    bus.x1 = 4'd0; bus.y1 = 4'd0; bus.x2 = 4'd0; bus.y2 = 4'd0;
    bus.x3 = 4'd0; bus.y3 = 4'd0; bus.x4 = 4'd0; bus.y4 = 4'd0;
    step();
    bus.top_flag = 1'b0;
  endtask

  // Called on entry to CLEAR; counts cycles until GEN, then steps into PLAY.
  task automatic run_clear(input int exp_cycles);
    n_cyc = 0;
    while (bus.gen_flag !== 1'b1 && n_cyc < 40) begin
      step();
      n_cyc++;
    end
    check("clear_cycles", 32'(n_cyc), 32'(exp_cycles));
    step();
    check("play_after_gen", 32'(bus.state), 32'd2);
    check("gen_one_cycle", 32'(bus.gen_flag), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset_n = 1'b0;
    bus.Start = 1'b0; bus.Ack = 1'b0; bus.bottom_flag = 1'b0; bus.top_flag = 1'b0;
    bus.x1 = '0; bus.y1 = '0; bus.x2 = '0; bus.y2 = '0;
    bus.x3 = '0; bus.y3 = '0; bus.x4 = '0; bus.y4 = '0;
    step();
    step();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_arr0", 32'(bus.arr0), 32'd0);
    check("rst_gen", 32'(bus.gen_flag), 32'd0);
    check("rst_over", 32'(bus.game_over), 32'd0);
    check("rst_lines", 32'(bus.lines_cleared), 32'd0);

    Reset_n = 1'b1;
    bus.Ack = 1'b1;
    step();
    check("idle_ack_ignored", 32'(bus.state), 32'd0);
    bus.Ack = 1'b0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("gen_state", 32'(bus.state), 32'd1);
    check("gen_flag_high", 32'(bus.gen_flag), 32'd1);
    step();
    check("play_state", 32'(bus.state), 32'd2);
    check("gen_flag_low", 32'(bus.gen_flag), 32'd0);

    bus.Start = 1'b1;
    bus.Ack = 1'b1;
    step();
    bus.Start = 1'b0;
    bus.Ack = 1'b0;
    check("play_waits", 32'(bus.state), 32'd2);

    lock_piece(4, 0, 5, 0, 6, 0, 7, 0, 1'b0);
    check("p1_clear_state", 32'(bus.state), 32'd4);
    check("p1_arr0", 32'(bus.arr0), 32'h0F0);
    run_clear(12);
    check("p1_arr0_kept", 32'(bus.arr0), 32'h0F0);

    lock_piece(8, 0, 9, 0, 3, 1, 13, 13, 1'b0);
    check("p2_arr0", 32'(bus.arr0), 32'h3F0);
    check("p2_arr1", 32'(bus.arr1), 32'h008);
    run_clear(12);

    lock_piece(0, 0, 1, 0, 2, 0, 3, 0, 1'b0);
    check("p3_arr0_full", 32'(bus.arr0), 32'h3FF);
    run_clear(13);
    check("p3_arr0", 32'(bus.arr0), 32'h008);
    check("p3_arr1", 32'(bus.arr1), 32'h000);
    check("p3_lines", 32'(bus.lines_cleared), 32'(exp_lines(1)));

    lock_piece(0, 0, 1, 0, 2, 0, 4, 0, 1'b0);
    run_clear(12);
    lock_piece(5, 0, 6, 0, 7, 0, 8, 0, 1'b0);
    run_clear(12);
    lock_piece(0, 1, 1, 1, 2, 1, 3, 1, 1'b0);
    run_clear(12);
    lock_piece(4, 1, 5, 1, 6, 1, 7, 1, 1'b0);
    run_clear(12);
    lock_piece(8, 1, 8, 1, 3, 0, 0, 2, 1'b0);
    check("dup_arr0", 32'(bus.arr0), 32'h1FF);
    check("dup_arr1", 32'(bus.arr1), 32'h1FF);
    check("dup_arr2", 32'(bus.arr2), 32'h001);
    run_clear(12);

    lock_piece(9, 0, 9, 1, 9, 11, 13, 13, 1'b0);
    check("two_arr0_full", 32'(bus.arr0), 32'h3FF);
    check("two_arr1_full", 32'(bus.arr1), 32'h3FF);
    check("two_arr11", 32'(bus.arr11), 32'h200);
    run_clear(14);
    check("two_arr0", 32'(bus.arr0), 32'h001);
    check("two_arr1", 32'(bus.arr1), 32'h000);
    check("two_arr9", 32'(bus.arr9), 32'h200);
    check("two_arr10", 32'(bus.arr10), 32'h000);
    check("two_arr11_zero", 32'(bus.arr11), 32'h000);
    check("two_lines", 32'(bus.lines_cleared), 32'(exp_lines(3)));

    lock_piece(13, 13, 10, 0, 0, 12, 15, 2, 1'b0);
    check("oob_arr0", 32'(bus.arr0), 32'h001);
    check("oob_arr2", 32'(bus.arr2), 32'h000);
    check("oob_arr9", 32'(bus.arr9), 32'h200);
    run_clear(12);

    lock_piece(0, 11, 1, 11, 13, 13, 13, 13, 1'b1);
    check("over_state", 32'(bus.state), 32'd5);
    check("over_flag", 32'(bus.game_over), 32'd1);
    check("over_no_gen", 32'(bus.gen_flag), 32'd0);
    check("over_arr11", 32'(bus.arr11), 32'h003);
    bus.Start = 1'b1;
    bus.bottom_flag = 1'b1;
    step();
    step();
    bus.Start = 1'b0;
    bus.bottom_flag = 1'b0;
    check("over_holds", 32'(bus.state), 32'd5);
    check("over_frozen", 32'(bus.arr0), 32'h001);
    bus.Ack = 1'b1;
    step();
    bus.Ack = 1'b0;
    check("ack_idle", 32'(bus.state), 32'd0);
    check("ack_over_low", 32'(bus.game_over), 32'd0);
    check("ack_arr0", 32'(bus.arr0), 32'h000);
    check("ack_arr9", 32'(bus.arr9), 32'h000);
    check("ack_arr11", 32'(bus.arr11), 32'h000);
    check("ack_lines_kept", 32'(bus.lines_cleared), 32'(exp_lines(3)));
    step();
    check("idle_holds", 32'(bus.state), 32'd0);

    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("restart_gen", 32'(bus.state), 32'd1);
    check("restart_lines", 32'(bus.lines_cleared), 32'd0);
    step();

    lock_piece(0, 0, 1, 0, 2, 0, 3, 0, 1'b0);
    run_clear(12);
    lock_piece(4, 0, 5, 0, 6, 0, 7, 0, 1'b0);
    run_clear(12);
    lock_piece(8, 0, 9, 0, 2, 1, 13, 13, 1'b0);
    check("r3_arr0_full", 32'(bus.arr0), 32'h3FF);
    check("r3_arr1", 32'(bus.arr1), 32'h004);
    step();
    check("r3_shift_arr0", 32'(bus.arr0), 32'h004);
    check("r3_lines", 32'(bus.lines_cleared), 32'(exp_lines(1)));
    step();
    check("r3_mid_clear", 32'(bus.state), 32'd4);
    Reset_n = 1'b0;
    #1;
    check("arst_state", 32'(bus.state), 32'd0);
    check("arst_arr0", 32'(bus.arr0), 32'h000);
    check("arst_arr1", 32'(bus.arr1), 32'h000);
    check("arst_gen", 32'(bus.gen_flag), 32'd0);
    check("arst_over", 32'(bus.game_over), 32'd0);
    check("arst_lines", 32'(bus.lines_cleared), 32'd0);
    Reset_n = 1'b1;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    check("post_rst_gen", 32'(bus.state), 32'd1);
    step();
    check("post_rst_play", 32'(bus.state), 32'd2);
    check("post_rst_arr0", 32'(bus.arr0), 32'h000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
